// File: rtl/switch_debounce.sv
// switch_debounce
//   Multi-channel switch debouncer. Each raw input bit is brought into the
//   SYSTEMCLOCK domain by a two-flop synchronizer. A new level is accepted
//   only after the synchronized value has differed from the current
//   debounced level for DEBOUNCE_CYCLES consecutive cycles. Acceptance
//   produces a one-cycle rise or fall pulse for that channel.
//
// Ports
//   SYSTEMCLOCK            in   1      single clock, rising edge
//   PUSH_BUTTON_RESET_RAW  in   1      asynchronous active-low reset
//   gpio_switch_raw        in   WIDTH  raw asynchronous switch levels
//   gpio_switch            out  WIDTH  debounced levels (registered)
//   switch_rise            out  WIDTH  one-cycle pulse on accepted 0->1
//   switch_fall            out  WIDTH  one-cycle pulse on accepted 1->0
//   switch_changed         out  1      OR of all rise/fall bits (registered)
//
// Per-channel states
//   state    | meaning
//   STABLE   | sync2 matches gpio_switch, counter is 0
//   SETTLING | sync2 differs, counter holds consecutive differing cycles
module switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             SYSTEMCLOCK,
  input  logic             PUSH_BUTTON_RESET_RAW,
  input  logic [WIDTH-1:0] gpio_switch_raw,
  output logic [WIDTH-1:0] gpio_switch,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             switch_changed
);

  typedef enum logic {STABLE, SETTLING} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] accept;
  state_t           state [WIDTH];
  logic [CNT_W-1:0] cnt   [WIDTH];

  // A channel accepts when it has already seen DEBOUNCE_CYCLES-1 differing
  // cycles and still differs. With DEBOUNCE_CYCLES == 1 that happens on the
  // very first differing cycle, straight out of STABLE.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] != gpio_switch[i]) begin
        accept[i] = (state[i] == STABLE) ? (LAST == '0) : (cnt[i] == LAST);
      end
    end
  end

  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      sync1          <= '0;
      sync2          <= '0;
      gpio_switch    <= '0;
      switch_rise    <= '0;
      switch_fall    <= '0;
      switch_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1          <= gpio_switch_raw;
      sync2          <= sync1;
      gpio_switch    <= gpio_switch ^ accept;
      switch_rise    <= accept & sync2;
      switch_fall    <= accept & ~sync2;
      switch_changed <= |accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (accept[i]) begin
          state[i] <= STABLE;
          cnt[i]   <= '0;
        end else if (sync2[i] != gpio_switch[i]) begin
          // From STABLE the counter is 0, so this loads 1 on entry.
          state[i] <= SETTLING;
          cnt[i]   <= cnt[i] + CNT_W'(1);
        end else begin
          state[i] <= STABLE;
          cnt[i]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce
//   Drives switch_debounce (WIDTH=4, DEBOUNCE_CYCLES=8) with directed and
//   random raw patterns. The reference model keeps the raw level sampled at
//   every clock edge; a channel's debounced level flips at an edge when the
//   last DEBOUNCE_CYCLES synchronized samples (raw delayed by two edges) all
//   differ from the current debounced level.
module tb_switch_debounce;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] gpio_switch;
  logic [W-1:0] switch_rise;
  logic [W-1:0] switch_fall;
  logic         switch_changed;

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .SYSTEMCLOCK          (clk),
    .PUSH_BUTTON_RESET_RAW(rst_n),
    .gpio_switch_raw      (raw),
    .gpio_switch          (gpio_switch),
    .switch_rise          (switch_rise),
    .switch_fall          (switch_fall),
    .switch_changed       (switch_changed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] samp [$];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_chg;

  task automatic model_reset();
    samp.delete();
    for (int j = 0; j < D + 2; j++) samp.push_back('0);
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
  endtask

  // Apply one raw value for one clock edge, advance the model, and return
  // at the following falling edge where outputs are stable.
  task automatic tick(input logic [W-1:0] v);
    logic [W-1:0] acc;
    int last;
    raw = v;
    @(posedge clk);
    samp.push_back(v);
    last = samp.size() - 1;
    acc = '0;
    for (int i = 0; i < W; i++) begin
      bit all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++)
        if (samp[last-j][i] == m_out[i]) all_diff = 1'b0;
      acc[i] = all_diff;
    end
    m_rise = acc & ~m_out;
    m_fall = acc & m_out;
    m_chg  = |acc;
    m_out  = m_out ^ acc;
    while (samp.size() > D + 4) void'(samp.pop_front());
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw = 4'($urandom_range(0, 15));
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({gpio_switch, switch_rise, switch_fall, switch_changed} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state: got %b want 0",
               {gpio_switch, switch_rise, switch_fall, switch_changed});
    end
    raw = '0;
    rst_n = 1'b1;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      tick(4'b0000);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !== 13'd0) begin
        n_err++;
        $display("FAIL reset_idle t=%0d: got %b want 0", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed});
      end
    end
  endtask

  task automatic test_single_rise();
    int first = 0;
    for (int t = 1; t <= 14; t++) begin
      tick(4'b0001);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        $display("FAIL single_rise_model t=%0d: got %b want %b", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed},
                 {m_out, m_rise, m_fall, m_chg});
      end
      if (t == 10) begin
        n_cmp++;
        if (switch_rise !== 4'b0001 || switch_changed !== 1'b1) begin
          n_err++;
          $display("FAIL single_rise_pulse: rise=%b chg=%b want 0001/1",
                   switch_rise, switch_changed);
        end
      end
      if (gpio_switch[0] && first == 0) first = t;
    end
    n_cmp++;
    if (first != 10) begin
      n_err++;
      $display("FAIL single_rise_latency: got %0d edges want 10", first);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int high = 0;
    for (int t = 0; t < 48; t++) begin
      tick((t < 40 && t % 5 == 0) ? 4'b0011 : 4'b0001);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        $display("FAIL glitch_model t=%0d: got %b want %b", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed},
                 {m_out, m_rise, m_fall, m_chg});
      end
      if (switch_changed || switch_rise != 0 || switch_fall != 0) pulses++;
      if (gpio_switch[1]) high++;
    end
    n_cmp++;
    if (pulses != 0 || high != 0) begin
      n_err++;
      $display("FAIL glitch_reject: pulses=%0d bit1_high=%0d want 0/0", pulses, high);
    end
  endtask

  task automatic test_simultaneous();
    for (int t = 1; t <= 12; t++) begin
      tick(4'b1101);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        $display("FAIL simul_model t=%0d: got %b want %b", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed},
                 {m_out, m_rise, m_fall, m_chg});
      end
      if (t == 10) begin
        n_cmp++;
        if (switch_rise !== 4'b1100 || gpio_switch !== 4'b1101) begin
          n_err++;
          $display("FAIL simul_pulse: rise=%b out=%b want 1100/1101",
                   switch_rise, gpio_switch);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int fall_at = 0;
    int falls = 0;
    for (int t = 1; t <= 24; t++) begin
      tick((t == 8) ? 4'b1101 : 4'b1100);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        $display("FAIL bounce_model t=%0d: got %b want %b", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed},
                 {m_out, m_rise, m_fall, m_chg});
      end
      if (switch_fall != 0) begin
        falls++;
        fall_at = t;
      end
    end
    n_cmp++;
    if (falls != 1 || fall_at != 18 || gpio_switch !== 4'b1100) begin
      n_err++;
      $display("FAIL bounce_fall: count=%0d at=%0d out=%b want 1/18/1100",
               falls, fall_at, gpio_switch);
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = 0;
    for (int t = 1; t <= 7; t++) tick(4'b1101);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gpio_switch, switch_rise, switch_fall, switch_changed} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: got %b want 0",
               {gpio_switch, switch_rise, switch_fall, switch_changed});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int t = 1; t <= 12; t++) begin
      tick(4'b1101);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        $display("FAIL reset_mid_model t=%0d: got %b want %b", t,
                 {gpio_switch, switch_rise, switch_fall, switch_changed},
                 {m_out, m_rise, m_fall, m_chg});
      end
      if (switch_rise != 0 && rise_at == 0) rise_at = t;
    end
    n_cmp++;
    if (rise_at != 10) begin
      n_err++;
      $display("FAIL reset_mid_rise: got edge %0d want 10", rise_at);
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    for (int t = 0; t < 1000; t++) begin
      tick(4'b1101);
      if (switch_changed || switch_rise != 0 || switch_fall != 0 ||
          gpio_switch !== 4'b1101) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL hold_quiet: disturbed cycles=%0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] lvl = 4'b1101;
    logic [W-1:0] v;
    int bad = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 19) == 0) lvl = lvl ^ (4'b0001 << $urandom_range(0, 3));
      v = lvl;
      if ($urandom_range(0, 9) == 0) v = v ^ 4'($urandom_range(0, 15));
      tick(v);
      n_cmp++;
      if ({gpio_switch, switch_rise, switch_fall, switch_changed} !==
          {m_out, m_rise, m_fall, m_chg}) begin
        n_err++;
        if (bad < 10)
          $display("FAIL random_model t=%0d: got %b want %b", t,
                   {gpio_switch, switch_rise, switch_fall, switch_changed},
                   {m_out, m_rise, m_fall, m_chg});
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_bounce();
    test_reset_mid();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1 to 2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 20: width of each per-channel settle counter.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port SYSTEMCLOCK, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port PUSH_BUTTON_RESET_RAW, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port gpio_switch_raw, input, WIDTH: raw asynchronous board switch levels.
REQ-008 SHALL have port gpio_switch, output, WIDTH: debounced registered levels feeding the top-level LED logic.
REQ-009 SHALL have port switch_rise, output, WIDTH: one-cycle pulse per channel when its gpio_switch goes 0->1.
REQ-010 SHALL have port switch_fall, output, WIDTH: one-cycle pulse per channel when its gpio_switch goes 1->0.
REQ-011 SHALL have port switch_changed, output, 1: OR of all switch_rise and switch_fall bits, registered with them.

Function
REQ-012 SHALL pass each raw bit through a two-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-013 SHALL keep per channel a two-state machine: STABLE (sync2 == gpio_switch, counter 0) and SETTLING (sync2 != gpio_switch).
REQ-014 STABLE -> SETTLING when sync2 differs from gpio_switch; counter loads 1 on that edge.
REQ-015 In SETTLING, while sync2 still differs, counter increments by 1 each cycle.
REQ-016 In SETTLING, if sync2 equals gpio_switch on any cycle, counter clears to 0 and state returns to STABLE; gpio_switch and pulses unchanged (glitch rejected).
REQ-017 When sync2 differs and counter == DEBOUNCE_CYCLES-1, next edge: gpio_switch bit takes sync2, counter clears, state STABLE, matching rise/fall bit asserts for exactly that one cycle.
REQ-018 Latency: a clean raw step settled before edge N appears on gpio_switch after edge N+1+DEBOUNCE_CYCLES (2 sync + DEBOUNCE_CYCLES).
REQ-019 DEBOUNCE_CYCLES == 1: gpio_switch follows sync2 with one-cycle delay, no settling.
REQ-020 Counter SHALL never exceed DEBOUNCE_CYCLES-1 nor wrap; compare is unsigned on CNT_W bits.
REQ-021 Channels SHALL be fully independent; simultaneous acceptance on several channels asserts all corresponding pulse bits in the same cycle.
REQ-022 switch_rise and switch_fall for one channel SHALL never assert together; no pulse without a gpio_switch change.
REQ-023 gpio_switch, switch_rise, switch_fall, switch_changed SHALL be driven directly from flops.

Reset
REQ-024 While PUSH_BUTTON_RESET_RAW is low: sync1, sync2, gpio_switch, counters, switch_rise, switch_fall, switch_changed all 0, state STABLE, immediately without clock.
REQ-025 Reset assertion mid-SETTLING SHALL discard the pending count; no pulse issued.
REQ-026 After release, a raw input already high SHALL be accepted as a normal 0->1 transition (rise pulse after 2+DEBOUNCE_CYCLES edges).

Verification (DEBOUNCE_CYCLES=8, WIDTH=4)
REQ-027 Reset, raw=4'b0000, step bit0 to 1 -> gpio_switch=4'b0001 exactly 10 edges later, switch_rise=4'b0001 and switch_changed=1 for one cycle.
REQ-028 Bit1 toggled 1 cycle high every 5 cycles for 40 cycles, then low -> gpio_switch[1] stays 0, no pulses.
REQ-029 Bits 2 and 3 stepped 0->1 on same edge -> both accepted same cycle, switch_rise=4'b1100 one cycle.
REQ-030 gpio_switch=4'b0001, bit0 falls, one-cycle bounce back to 1 at count 7, then stays 0 -> fall accepted 8 cycles after the bounce ends, switch_fall=4'b0001 once.
REQ-031 Reset asserted asynchronously at count 5 of a rising settle -> all outputs 0 immediately; after release with raw still 1, rise pulse 10 edges later.
REQ-032 Raw held constant 1000 cycles after acceptance -> no further pulses, counters remain 0.
